// File: rtl/stream_arb_mux.sv
// Registered N:1 valid/ready stream mux with round-robin or fixed-priority
// arbitration and optional packet locking (grant held until in_last).

module stream_arb_mux_lane #(
    parameter int WIDTH = 32
) (
    input  logic             gnt,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    output logic [WIDTH-1:0] data_m,
    output logic             last_m
);
    // Masked per-lane contribution; the top ORs all lanes together.
    assign data_m = gnt ? data : '0;
    assign last_m = gnt & last;
endmodule

module stream_arb_mux #(
    parameter int WIDTH    = 32,
    parameter int N        = 4,
    parameter int RR_MODE  = 1,
    parameter int LOCK_PKT = 1,
    parameter int CHAN_W   = (N > 1 ? $clog2(N) : 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CHAN_W-1:0]    out_chan
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t state_q, state_d;
    logic [CHAN_W-1:0] lock_chan_q, lock_chan_d;
    logic [CHAN_W-1:0] ptr_q, ptr_d;

    logic                    load, xfer;
    logic [N-1:0]            grant;
    logic [CHAN_W-1:0]       sel;
    logic [N-1:0][WIDTH-1:0] lane_data;
    logic [N-1:0]            lane_last;
    logic [WIDTH-1:0]        mux_data;
    logic                    mux_last;
    logic                    found;
    int                      idx;

    // Arbitration: locked channel only, else first valid from the pointer.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (state_q == LOCKED) begin
            grant[lock_chan_q] = in_valid[lock_chan_q];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (RR_MODE != 0) ? ((int'(ptr_q) + k) % N) : k;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    assign xfer     = |in_ready;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel = CHAN_W'(i);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        stream_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
            .gnt    (grant[i]),
            .data   (in_data[i*WIDTH +: WIDTH]),
            .last   (in_last[i]),
            .data_m (lane_data[i]),
            .last_m (lane_last[i])
        );
    end

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | lane_data[i];
            mux_last = mux_last | lane_last[i];
        end
    end

    // Lock FSM and pointer; the pointer only moves on beats that end unlocked.
    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            if (LOCK_PKT != 0) begin
                if (state_q == UNLOCKED && !mux_last) begin
                    state_d     = LOCKED;
                    lock_chan_d = sel;
                end else if (state_q == LOCKED && mux_last) begin
                    state_d     = UNLOCKED;
                    lock_chan_d = '0;
                end
            end
            if (RR_MODE != 0 && state_d == UNLOCKED) begin
                ptr_d = (int'(sel) + 1 == N) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            lock_chan_q <= '0;
            ptr_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_chan    <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            ptr_q       <= ptr_d;
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= mux_data;
                    out_last <= mux_last;
                    out_chan <= sel;
                end
            end
        end
    end
endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Registered N:1 stream multiplexer with valid/ready handshake on every input channel and on the output.
- Arbitration mode is selectable: round-robin or fixed-priority.
- Optional packet locking holds a grant until the granted channel presents its last beat.
- Sits between multiple producers (DMA channels, bus masters) and one shared consumer port; it is the sequential, flow-controlled successor to the combinational mux family.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels, 1..32.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- LOCK_PKT, 1, 1 = grant held from first beat to in_last beat, 0 = re-arbitrate every beat.
- CHAN_W, (N>1 ? $clog2(N) : 1), width of the channel-index output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready, one-hot or zero.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N  per-channel end-of-packet flag.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_chan  output  CHAN_W  index of the source channel of the current out beat.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge), all of the following are cleared:
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - RR pointer=0.
  - Lock state=UNLOCKED, locked channel=0.
- in_ready is forced to 0 during reset cycles.
- load = !out_valid || out_ready.
- in_ready = load ? grant : 0, where grant is combinational and one-hot/zero.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - At the next edge: out_data=in_data[i], out_last=in_last[i], out_chan=i, out_valid=1.
- If load and no transfer occurs, out_valid goes to 0 at the next edge.
- While out_valid && !out_ready, out_data, out_last and out_chan are held stable.
- Latency is 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- Grant, UNLOCKED state:
  - RR_MODE=1: first channel with in_valid=1 searching upward from the pointer, wrapping at N-1 to 0.
  - RR_MODE=0: lowest-index channel with in_valid=1.
  - No valid channel: grant=0.
- Grant, LOCKED state: grant = one-hot of the locked channel only, regardless of the other in_valid bits. No grant is given if that channel is not valid; the block waits.
- Lock state machine, LOCK_PKT=1:
  - UNLOCKED -> LOCKED on a transfer with in_last=0; the locked channel is recorded.
  - LOCKED -> UNLOCKED on a transfer from the locked channel with in_last=1.
  - A single-beat packet (in_last=1 on the first beat) stays UNLOCKED.
- LOCK_PKT=0: the state is always UNLOCKED and in_last is passed through only.
- Pointer update (RR_MODE=1): on a transfer that leaves the block UNLOCKED, pointer = (i+1) mod N. There is no pointer update while LOCKED or on mid-packet beats.
- Pointer with RR_MODE=0: the pointer stays 0.
- in_valid deasserted by the locked producer mid-packet: the block stays LOCKED and the other channels are starved. This is intended.
- in_data is sampled only on a transfer; it is don't-care otherwise.
- Simultaneous out_ready and a new transfer: the output is replaced in the same edge, with no bubble.
- Reset mid-packet: the lock is dropped; the in-flight output beat is discarded (out_valid=0).
- N=1: grant = in_valid[0] when load; out_chan is always 0.

Test Plan:
- Reset, then N=4, RR, in_valid=4'b1111 all with last=1, out_ready=1 held:
  - out_chan sequence 0,1,2,3,0 on consecutive cycles.
  - out_valid=1 from cycle 2 after the first request.
- RR_MODE=0, in_valid=4'b1010 constant -> out_chan is always 1; channel 3 is never granted.
- LOCK_PKT=1, ch2 sends 3 beats (data 8'hA0,A1,A2, last on A2) while ch0 is valid throughout:
  - out_chan=2 for all three beats, then 0 next.
  - in_ready[0]=0 during the packet.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 8'h55:
  - out_data stays 8'h55 and in_ready=0.
  - On out_ready=1, the next beat is accepted in the same cycle.
- Reset asserted while LOCKED on ch1 mid-packet:
  - Next cycle out_valid=0.
  - With ch0 and ch1 valid, ch0 is granted first (pointer=0, unlocked).
- Empty/idle: in_valid=0 with out_ready=1 -> out_valid drops to 0 one cycle after the last beat; in_ready stays 0.
